// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
//
// Write-side memory unit of the single-issue RISC-V core. Decodes SB/SH/SW,
// forms the effective address rs1_val + imm, builds the word-aligned address,
// lane-replicated write data and byte enables, and drives a single write to
// data memory. The PC is held through stall_pc while the write is in flight,
// and the wait for mem_ready is bounded by WAIT_LIMIT cycles.
//
// Parameters:
//   WAIT_LIMIT        maximum WRITE cycles spent waiting for mem_ready
//
// Configuration macro:
//   STORE_MISALIGN_TRAP_EN  when defined, SH with ea[0]=1 and SW with
//                           ea[1:0]!=0 are rejected and reported through a
//                           one-cycle store_misaligned pulse; when undefined,
//                           such stores align down and store_misaligned is 0.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   rs1_val, rs2_val    base address operand, store data operand
//   imm                 sign-extended S-type offset
//   store_control       00 NOP, 01 SB, 10 SH, 11 SW
//   mem_ready           memory accepts the write this cycle
//   stall_pc            hold PC / current instruction
//   ignore_curr_inst    registered copy of stall_pc
//   mem_rw_mode         0 = write, 1 = read (idle)
//   mem_wr_en           write strobe
//   mem_addr            word address (bits [1:0] = 0)
//   mem_wr_data         write data
//   mem_byte_en         byte lane enables
//   store_misaligned    pulse: misaligned store rejected
//   store_timeout       pulse: store aborted after WAIT_LIMIT cycles
//
// Memory handshake: while in WRITE, mem_wr_en is high and address, data and
// byte enables are held stable. The write commits at the rising edge that ends
// a cycle in which mem_ready is high; mem_ready is ignored outside WRITE.
// -----------------------------------------------------------------------------
module store_unit #(
  parameter int WAIT_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [1:0]  store_control,
  input  logic        mem_ready,
  output logic        stall_pc,
  output logic        ignore_curr_inst,
  output logic        mem_rw_mode,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_byte_en,
  output logic        store_misaligned,
  output logic        store_timeout
);

  localparam logic [1:0] ST_NOP = 2'b00;
  localparam logic [1:0] SB     = 2'b01;
  localparam logic [1:0] SH     = 2'b10;
  localparam logic [1:0] SW     = 2'b11;

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_LIMIT - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [31:0]     addr_q;
  logic [31:0]     data_q;
  logic [3:0]      be_q;

  logic [31:0]     ea;
  logic [1:0]      off;
  logic [31:0]     lane_addr;
  logic [31:0]     lane_data;
  logic [3:0]      lane_be;
  logic            start_store;
  logic            reject;
  logic            accept;

  // Effective address and lane formatting for the instruction in decode.
  always_comb begin
    ea        = rs1_val + imm;
    off       = ea[1:0];
    lane_addr = {ea[31:2], 2'b00};
    lane_data = 32'h0;
    lane_be   = 4'b0000;
    case (store_control)
      SB: begin
        lane_data = {4{rs2_val[7:0]}};
        lane_be   = 4'b0001 << off;
      end
      SH: begin
        lane_data = {2{rs2_val[15:0]}};
        // Half-word lane picked by off[1]; off[0] is dropped (aligns down).
        lane_be   = 4'b0011 << {off[1], 1'b0};
      end
      SW: begin
        lane_data = rs2_val;
        lane_be   = 4'b1111;
      end
      default: begin
        lane_data = 32'h0;
        lane_be   = 4'b0000;
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign reject = ((store_control == SH) && off[0]) ||
                  ((store_control == SW) && (off != 2'b00));
`else
  assign reject = 1'b0;
`endif

  // A store seen while ignore_curr_inst is high is the held copy of the
  // instruction that was just executed, so it never starts a new write.
  assign start_store = (state == S_IDLE) && (store_control != ST_NOP) &&
                       !ignore_curr_inst;
  assign accept      = start_store && !reject;

  assign stall_pc    = !i_rst && (accept || (state == S_WRITE));

  // Memory-side outputs are decoded from state and driven from registers;
  // everything is zero while idle.
  assign mem_wr_en   = (state == S_WRITE);
  assign mem_rw_mode = (state != S_WRITE);
  assign mem_addr    = (state == S_WRITE) ? addr_q : 32'h0;
  assign mem_wr_data = (state == S_WRITE) ? data_q : 32'h0;
  assign mem_byte_en = (state == S_WRITE) ? be_q   : 4'b0000;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= S_IDLE;
      wait_cnt         <= '0;
      ignore_curr_inst <= 1'b0;
      store_timeout    <= 1'b0;
      addr_q           <= 32'h0;
      data_q           <= 32'h0;
      be_q             <= 4'b0000;
    end else begin
      ignore_curr_inst <= stall_pc;
      store_timeout    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_WRITE;
            wait_cnt <= '0;
            addr_q   <= lane_addr;
            data_q   <= lane_data;
            be_q     <= lane_be;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == LAST_WAIT) begin
            // Last permitted wait cycle expired: abort without writing.
            state         <= S_IDLE;
            wait_cnt      <= '0;
            store_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      store_misaligned <= 1'b0;
    end else begin
      store_misaligned <= start_store && reject;
    end
  end
`else
  assign store_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
//
// Self-checking bench for store_unit. Inputs are driven 1 ns after the rising
// edge and outputs are sampled on the falling edge. Expected values come from
// a transaction-level model: the effective address, aligned word address,
// byte lanes and replicated data are computed with plain arithmetic, and the
// cycle-by-cycle expectations follow the documented timing (accept, n WRITE
// cycles, one idle cycle with ignore_curr_inst high).
// -----------------------------------------------------------------------------
module tb_store_unit;

  localparam int WAIT_LIMIT = 8;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [1:0]  store_control;
  logic        mem_ready;
  logic        stall_pc;
  logic        ignore_curr_inst;
  logic        mem_rw_mode;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;
  logic        store_misaligned;
  logic        store_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  store_unit #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .imm              (imm),
    .store_control    (store_control),
    .mem_ready        (mem_ready),
    .stall_pc         (stall_pc),
    .ignore_curr_inst (ignore_curr_inst),
    .mem_rw_mode      (mem_rw_mode),
    .mem_wr_en        (mem_wr_en),
    .mem_addr         (mem_addr),
    .mem_wr_data      (mem_wr_data),
    .mem_byte_en      (mem_byte_en),
    .store_misaligned (store_misaligned),
    .store_timeout    (store_timeout)
  );

  // ---------------- clock / watchdog ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_store(input logic [1:0] c, input logic [31:0] ea,
                                      input logic [31:0] r2, output logic [31:0] a,
                                      output logic [31:0] d, output logic [3:0] be);
    int off;
    off = int'(ea % 32'd4);
    a   = ea - 32'(off);
    case (c)
      2'd1: begin
        be = 4'(1 << off);
        d  = (r2 & 32'hFF) * 32'h0101_0101;
      end
      2'd2: begin
        be = 4'(3 << (2 * (off / 2)));
        d  = (r2 & 32'hFFFF) * 32'h0001_0001;
      end
      default: begin
        be = 4'hF;
        d  = r2;
      end
    endcase
  endfunction

  function automatic bit model_reject(input logic [1:0] c, input logic [31:0] ea);
`ifdef STORE_MISALIGN_TRAP_EN
    int off;
    off = int'(ea % 32'd4);
    return ((c == 2'd2) && (off % 2 != 0)) || ((c == 2'd3) && (off != 0));
`else
    return (c == 2'b00) && (ea != ea);
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  // One store transaction. rdy_at = WRITE cycle in which mem_ready rises
  // (0 = never). b2b = return right after the idle cycle n+1 so the caller
  // can present the next store in cycle n+2.
  task automatic run_store(input string tag, input logic [1:0] ctrl,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] im, input int rdy_at, input bit b2b);
    logic [31:0] ea, e_addr, e_data;
    logic [3:0]  e_be;
    logic [69:0] got_bus, exp_bus;
    bit          rej, to;
    int          n;
    ea  = r1 + im;
    model_store(ctrl, ea, r2, e_addr, e_data, e_be);
    rej = model_reject(ctrl, ea);

    store_control = ctrl;
    rs1_val       = r1;
    rs2_val       = r2;
    imm           = im;
    mem_ready     = 1'($urandom_range(0, 1));
    @(negedge i_clk);
    n_checks++;
    if ({stall_pc, ignore_curr_inst, mem_wr_en} !== {!rej, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s accept: stall/ignore/wr_en got %b%b%b required %b00",
               tag, stall_pc, ignore_curr_inst, mem_wr_en, !rej);
    end
    next_cycle();

    if (rej) begin
      store_control = 2'b00;
      @(negedge i_clk);
      n_checks++;
      if ({mem_wr_en, stall_pc, store_misaligned, store_timeout} !== 4'b0010) begin
        n_fail++;
        $display("FAIL %s reject_pulse: wr_en/stall/mis/to got %b%b%b%b required 0010",
                 tag, mem_wr_en, stall_pc, store_misaligned, store_timeout);
      end
      next_cycle();
      @(negedge i_clk);
      n_checks++;
      if ({mem_wr_en, store_misaligned} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s reject_after: wr_en/mis got %b%b required 00",
                 tag, mem_wr_en, store_misaligned);
      end
      next_cycle();
      return;
    end

    n  = 0;
    to = 1'b0;
    exp_bus = {1'b1, 1'b0, e_addr, e_data, e_be};
    for (int i = 1; i <= WAIT_LIMIT; i++) begin
      mem_ready = (i == rdy_at);
      @(negedge i_clk);
      got_bus = {mem_wr_en, mem_rw_mode, mem_addr, mem_wr_data, mem_byte_en};
      n_checks++;
      if (got_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL %s write_bus cyc%0d: got en=%b rw=%b a=%h d=%h be=%b required en=1 rw=0 a=%h d=%h be=%b",
                 tag, i, mem_wr_en, mem_rw_mode, mem_addr, mem_wr_data, mem_byte_en,
                 e_addr, e_data, e_be);
      end
      n_checks++;
      if ({stall_pc, ignore_curr_inst, store_timeout, store_misaligned} !== 4'b1100) begin
        n_fail++;
        $display("FAIL %s write_status cyc%0d: stall/ignore/to/mis got %b%b%b%b required 1100",
                 tag, i, stall_pc, ignore_curr_inst, store_timeout, store_misaligned);
      end
      next_cycle();
      n = i;
      if (i == rdy_at) break;
      if (i == WAIT_LIMIT) to = 1'b1;
    end

    // Cycle n+1: back in IDLE with the instruction still held.
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge i_clk);
    n_checks++;
    if ({mem_wr_en, mem_rw_mode, mem_addr, mem_wr_data, mem_byte_en} !== {1'b0, 1'b1, 68'h0}) begin
      n_fail++;
      $display("FAIL %s idle_bus after %0d writes: got en=%b rw=%b a=%h d=%h be=%b required en=0 rw=1 zeros",
               tag, n, mem_wr_en, mem_rw_mode, mem_addr, mem_wr_data, mem_byte_en);
    end
    n_checks++;
    if ({stall_pc, ignore_curr_inst, store_timeout} !== {1'b0, 1'b1, to}) begin
      n_fail++;
      $display("FAIL %s idle_status: stall/ignore/to got %b%b%b required 01%b",
               tag, stall_pc, ignore_curr_inst, store_timeout, to);
    end
    next_cycle();
    if (b2b) return;

    store_control = 2'b00;
    @(negedge i_clk);
    n_checks++;
    if ({mem_wr_en, stall_pc, ignore_curr_inst, store_timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s settle: wr_en/stall/ignore/to got %b%b%b%b required 0000",
               tag, mem_wr_en, stall_pc, ignore_curr_inst, store_timeout);
    end
    next_cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst         = 1'b1;
    store_control = 2'b11;
    rs1_val       = 32'h0;
    rs2_val       = 32'h0;
    imm           = 32'h0;
    mem_ready     = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge i_clk);
    n_checks++;
    if ({stall_pc, ignore_curr_inst, mem_rw_mode, mem_wr_en, mem_addr, mem_wr_data,
         mem_byte_en, store_misaligned, store_timeout} !== {4'b0010, 68'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_values: got stall=%b ign=%b rw=%b en=%b a=%h d=%h be=%b mis=%b to=%b required rw=1 rest 0",
               stall_pc, ignore_curr_inst, mem_rw_mode, mem_wr_en, mem_addr, mem_wr_data,
               mem_byte_en, store_misaligned, store_timeout);
    end
    next_cycle();
    store_control = 2'b00;
    i_rst         = 1'b0;
    next_cycle();
  endtask

  task automatic test_directed();
    run_store("sw_basic", 2'b11, 32'h1000, 32'hDEAD_BEEF, 32'd4, 1, 1'b0);
    run_store("sb_lane3", 2'b01, 32'h2000, 32'h0000_00A5, 32'd3, 1, 1'b0);
    run_store("sh_negimm", 2'b10, 32'h10, 32'h0000_1234, 32'hFFFF_FFFE, 1, 1'b0);
    run_store("sb_lane0", 2'b01, 32'h3001, 32'h1234_5677, 32'hFFFF_FFFF, 1, 1'b0);
  endtask

  task automatic test_timeout();
    run_store("sw_timeout", 2'b11, 32'h4000, 32'h0BAD_F00D, 32'd0, 0, 1'b0);
    run_store("sw_ready3", 2'b11, 32'h4000, 32'h600D_CAFE, 32'd8, 3, 1'b0);
    run_store("sw_ready_last", 2'b11, 32'h4100, 32'h1111_2222, 32'd0, WAIT_LIMIT, 1'b0);
  endtask

  task automatic test_misaligned();
    run_store("sw_mis", 2'b11, 32'h1000, 32'hCAFE_BABE, 32'd2, 1, 1'b0);
    run_store("sh_mis", 2'b10, 32'h1000, 32'h0000_BEEF, 32'd3, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_store("b2b_a", 2'b11, 32'h5000, 32'hAAAA_5555, 32'd0, 1, 1'b1);
    run_store("b2b_b", 2'b01, 32'h5000, 32'h0000_007E, 32'd1, 2, 1'b1);
    run_store("b2b_c", 2'b10, 32'h5000, 32'h0000_C0DE, 32'd2, 1, 1'b0);
  endtask

  task automatic test_reset_during_write();
    store_control = 2'b11;
    rs1_val       = 32'h6000;
    rs2_val       = 32'h1357_9BDF;
    imm           = 32'd0;
    mem_ready     = 1'b0;
    next_cycle();
    @(negedge i_clk);
    n_checks++;
    if (mem_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_write first_write: wr_en got %b required 1", mem_wr_en);
    end
    next_cycle();
    i_rst         = 1'b1;
    store_control = 2'b00;
    @(negedge i_clk);
    n_checks++;
    if (stall_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_write stall_in_reset: got %b required 0", stall_pc);
    end
    next_cycle();
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_checks++;
      if ({stall_pc, ignore_curr_inst, mem_rw_mode, mem_wr_en, mem_addr, mem_wr_data,
           mem_byte_en, store_misaligned, store_timeout} !== {4'b0010, 68'h0, 2'b00}) begin
        n_fail++;
        $display("FAIL rst_write after cyc%0d: got stall=%b ign=%b rw=%b en=%b a=%h d=%h be=%b mis=%b to=%b required rw=1 rest 0",
                 i, stall_pc, ignore_curr_inst, mem_rw_mode, mem_wr_en, mem_addr, mem_wr_data,
                 mem_byte_en, store_misaligned, store_timeout);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [11:0] i12;
    logic [1:0]  c;
    for (int k = 0; k < 40; k++) begin
      c   = 2'($urandom_range(1, 3));
      i12 = 12'($urandom);
      run_store($sformatf("rand%0d", k), c, $urandom, $urandom, {{20{i12[11]}}, i12},
                int'($urandom_range(0, WAIT_LIMIT)), 1'($urandom_range(0, 1)));
    end
    store_control = 2'b00;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_misaligned();
    test_back_to_back();
    test_reset_during_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
